// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient-load, weight-write and sample handshake bundle
// between the FIR coefficient controller and its neighbours.
interface fir_coeff_ctrl_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 7
);
    logic                  i_load_start;
    logic [DATA_WIDTH-1:0] iv_coeff;
    logic                  i_coeff_valid;
    logic                  o_coeff_ready;
    logic [ADDR_WIDTH-1:0] ov_wr_addr;
    logic [DATA_WIDTH-1:0] ov_wr_data;
    logic                  o_wr_en;
    logic                  o_bank_sel;
    logic [DATA_WIDTH-1:0] iv_sample;
    logic                  i_sample_valid;
    logic                  o_sample_ready;
    logic [DATA_WIDTH-1:0] ov_fir_din;
    logic                  o_fir_en;
    logic                  o_dout_valid;
    logic                  o_busy;
    logic                  o_load_done;
    logic                  o_load_abort;

    modport master (
        output i_load_start, iv_coeff, i_coeff_valid,
        output iv_sample, i_sample_valid,
        input  o_coeff_ready, ov_wr_addr, ov_wr_data, o_wr_en,
        input  o_bank_sel, o_sample_ready, ov_fir_din, o_fir_en,
        input  o_dout_valid, o_busy, o_load_done, o_load_abort
    );

    modport slave (
        input  i_load_start, iv_coeff, i_coeff_valid,
        input  iv_sample, i_sample_valid,
        output o_coeff_ready, ov_wr_addr, ov_wr_data, o_wr_en,
        output o_bank_sel, o_sample_ready, ov_fir_din, o_fir_en,
        output o_dout_valid, o_busy, o_load_done, o_load_abort
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: loads the shadow weight bank, swaps banks,
// gates the tap-chain enable and qualifies post-swap output samples.
module fir_coeff_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fir_coeff_ctrl_if.slave bus
);
    localparam int FW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FIR_DEPTH - 1);
    localparam logic [FW-1:0] FULL = FW'(FIR_DEPTH);
    localparam logic [FW-1:0] PRIMED = FW'(FIR_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_en;
    logic                  r_bank_sel;
    logic [DATA_WIDTH-1:0] r_fir_din;
    logic                  r_fir_en;
    logic [FW-1:0]         r_fill;
    logic                  r_dout_valid;
    logic                  r_load_done;
    logic                  r_load_abort;

    logic w_coeff_ready;
    logic w_sample_ready;
    logic w_cacc;
    logic w_sacc;
    logic w_abort;
    logic w_write;
    logic w_swap;
    logic w_start;

    always_comb begin
        w_next  = r_state;
        w_start = bus.i_load_start;
        w_coeff_ready  = (r_state == S_LOAD);
        w_sample_ready = i_rst && (r_state != S_SWAP);
        w_cacc  = bus.i_coeff_valid && w_coeff_ready;
        w_sacc  = bus.i_sample_valid && w_sample_ready;
        w_abort = w_coeff_ready && w_start;
        // a restart discards any coefficient offered in the same cycle
        w_write = w_cacc && !w_start;
        w_swap  = (r_state == S_SWAP);
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_LOAD;
            S_LOAD: if (w_write && r_cnt == LAST) w_next = S_SWAP;
            S_SWAP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_bank_sel   <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_abort <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_wr_en      <= w_write;
            r_bank_sel   <= r_bank_sel ^ w_swap;
            r_load_done  <= w_swap;
            r_load_abort <= w_abort;
            if ((r_state == S_IDLE && w_start) || w_abort)
                r_cnt <= '0;
            else if (w_write)
                r_cnt <= r_cnt + 1'b1;
            if (w_write) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= bus.iv_coeff;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fir_en     <= 1'b0;
            r_fir_din    <= '0;
            r_fill       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_fir_en <= w_sacc;
            if (w_sacc)
                r_fir_din <= bus.iv_sample;
            // the pulse issued during SWAP still uses the old bank
            if (w_swap)
                r_fill <= '0;
            else if (r_fir_en && r_fill != FULL)
                r_fill <= r_fill + 1'b1;
            r_dout_valid <= !w_swap && r_fir_en && (r_fill >= PRIMED);
        end
    end

    assign bus.o_coeff_ready  = w_coeff_ready;
    assign bus.o_sample_ready = w_sample_ready;
    assign bus.ov_wr_addr     = r_wr_addr;
    assign bus.ov_wr_data     = r_wr_data;
    assign bus.o_wr_en        = r_wr_en;
    assign bus.o_bank_sel     = r_bank_sel;
    assign bus.ov_fir_din     = r_fir_din;
    assign bus.o_fir_en       = r_fir_en;
    assign bus.o_dout_valid   = r_dout_valid;
    assign bus.o_busy         = (r_state != S_IDLE);
    assign bus.o_load_done    = r_load_done;
    assign bus.o_load_abort   = r_load_abort;
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl with a 4-tap configuration.
module tb_fir_coeff_ctrl;
    localparam int DW = 24;
    localparam int FD = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fir_coeff_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fir_coeff_ctrl #(
        .DATA_WIDTH(DW),
        .FIR_DEPTH (FD),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {5'd0, bus.o_coeff_ready, bus.ov_wr_addr, bus.ov_wr_data,
                bus.o_wr_en, bus.o_bank_sel, bus.o_sample_ready,
                bus.ov_fir_din, bus.o_fir_en, bus.o_dout_valid,
                bus.o_busy, bus.o_load_done, bus.o_load_abort};
    endfunction

    task automatic chk_wr(input string tag, input logic en,
                          input int addr, input int data);
        check({tag, "_en"}, 64'(bus.o_wr_en), 64'(en));
        if (en) begin
            check({tag, "_addr"}, 64'(bus.ov_wr_addr), 64'(addr));
            check({tag, "_data"}, 64'(bus.ov_wr_data), 64'(data));
        end
    endtask

    task automatic chk_smp(input string tag, input logic en,
                           input int din, input logic dv);
        check({tag, "_fen"}, 64'(bus.o_fir_en), 64'(en));
        check({tag, "_din"}, 64'(bus.ov_fir_din), 64'(din));
        check({tag, "_dv"}, 64'(bus.o_dout_valid), 64'(dv));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_load_start   = 1'b0;
        bus.iv_coeff       = '0;
        bus.i_coeff_valid  = 1'b0;
        bus.iv_sample      = '0;
        bus.i_sample_valid = 1'b0;
        repeat (2) tick();
        check("rst_outs", outs(), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_srdy", 64'(bus.o_sample_ready), 64'd1);

        // reset in the middle of a load
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        check("a_busy", 64'(bus.o_busy), 64'd1);
        check("a_crdy", 64'(bus.o_coeff_ready), 64'd1);
        bus.i_coeff_valid = 1'b1;
        bus.iv_coeff = 24'h0000A1;
        tick();
        chk_wr("a_w0", 1'b1, 0, 'hA1);
        bus.iv_coeff = 24'h0000A2;
        tick();
        chk_wr("a_w1", 1'b1, 1, 'hA2);
        #2 rst_n = 1'b0;
        #1;
        check("a_async_outs", outs(), 64'd0);
        bus.i_coeff_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // full back-to-back load
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        bus.i_coeff_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.iv_coeff = DW'(i + 1);
            tick();
            chk_wr($sformatf("b_w%0d", i), 1'b1, i, i + 1);
        end
        check("b_swap_crdy", 64'(bus.o_coeff_ready), 64'd0);
        check("b_swap_srdy", 64'(bus.o_sample_ready), 64'd0);
        check("b_swap_bank", 64'(bus.o_bank_sel), 64'd0);
        check("b_swap_done", 64'(bus.o_load_done), 64'd0);
        bus.i_coeff_valid = 1'b0;
        tick();
        chk_wr("b_post", 1'b0, 0, 0);
        check("b_done", 64'(bus.o_load_done), 64'd1);
        check("b_bank", 64'(bus.o_bank_sel), 64'd1);
        check("b_busy", 64'(bus.o_busy), 64'd0);
        tick();
        check("b_done_pulse", 64'(bus.o_load_done), 64'd0);

        // valid toggling, load_start during SWAP ignored
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.i_coeff_valid = (i % 2 == 0);
            bus.iv_coeff = DW'(32'h100 + i);
            tick();
            chk_wr($sformatf("c_w%0d", i), (i % 2 == 0), i / 2, 'h100 + i);
        end
        bus.i_coeff_valid = 1'b0;
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        check("c_done", 64'(bus.o_load_done), 64'd1);
        check("c_bank", 64'(bus.o_bank_sel), 64'd0);
        check("c_abort", 64'(bus.o_load_abort), 64'd0);
        tick();
        check("c_swap_start_ign", 64'(bus.o_busy), 64'd0);

        // restart mid-load with a coefficient in the same cycle
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        bus.i_coeff_valid = 1'b1;
        bus.iv_coeff = 24'h000201;
        tick();
        chk_wr("d_w0", 1'b1, 0, 'h201);
        bus.iv_coeff = 24'h000202;
        tick();
        chk_wr("d_w1", 1'b1, 1, 'h202);
        bus.i_load_start = 1'b1;
        bus.iv_coeff = 24'h0002FF;
        tick();
        bus.i_load_start = 1'b0;
        chk_wr("d_disc", 1'b0, 0, 0);
        check("d_abort", 64'(bus.o_load_abort), 64'd1);
        check("d_busy", 64'(bus.o_busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            bus.iv_coeff = DW'(32'h301 + i);
            tick();
            chk_wr($sformatf("d_r%0d", i), 1'b1, i, 'h301 + i);
            check($sformatf("d_r%0d_abort", i),
                  64'(bus.o_load_abort), 64'd0);
        end
        bus.i_coeff_valid = 1'b0;
        tick();
        check("d_done", 64'(bus.o_load_done), 64'd1);
        check("d_bank", 64'(bus.o_bank_sel), 64'd1);

        // samples streaming across a swap
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        bus.i_coeff_valid = 1'b1;
        bus.iv_coeff = 24'h000401;
        tick();
        chk_wr("e_w0", 1'b1, 0, 'h401);
        bus.i_sample_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.iv_coeff = DW'(32'h401 + i);
            bus.iv_sample = DW'(i);
            tick();
            chk_smp($sformatf("e_s%0d", i), 1'b1, i, 1'b0);
            check($sformatf("e_s%0d_srdy", i),
                  64'(bus.o_sample_ready), 64'(i != 3));
        end
        bus.i_coeff_valid = 1'b0;
        bus.iv_sample = 24'd4;
        tick();
        chk_smp("e_swp", 1'b0, 3, 1'b0);
        check("e_swp_srdy", 64'(bus.o_sample_ready), 64'd1);
        check("e_swp_done", 64'(bus.o_load_done), 64'd1);
        check("e_swp_bank", 64'(bus.o_bank_sel), 64'd0);
        for (int k = 1; k <= 7; k++) begin
            bus.iv_sample = DW'(3 + k);
            tick();
            chk_smp($sformatf("e_p%0d", k), 1'b1, 3 + k, (k >= 5));
        end
        bus.i_sample_valid = 1'b0;
        tick();
        chk_smp("e_tail0", 1'b0, 10, 1'b1);
        tick();
        chk_smp("e_tail1", 1'b0, 10, 1'b0);

        // reset clears the fill count
        rst_n = 1'b0;
        bus.i_sample_valid = 1'b1;
        tick();
        check("f_rst_outs", outs(), 64'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.iv_sample = DW'(32'h500 + i);
            tick();
            chk_smp($sformatf("f_s%0d", i), 1'b1, 'h500 + i, (i >= 5));
        end
        bus.i_sample_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
